// File: rtl/bram_port_arbiter_if.sv
// Requester-side port bundle for bram_port_arbiter.
// One instance per requester. The requester (master) drives the command
// and holds req until it sees gnt. The arbiter (slave) answers with the
// one-cycle gnt and rvalid pulses.
interface bram_port_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous block RAM
// between two requesters A and B.
// Each transaction is a fixed three-cycle sequence:
//   IDLE -> ACCESS -> RESP -> IDLE.
// The granted command is registered onto the RAM port during ACCESS.
// Read data returns from the RAM's registered output during RESP,
// flagged by a one-cycle rvalid pulse to the requester that issued it.
module bram_port_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active-low
    bram_port_arbiter_if.slave   a_if,
    bram_port_arbiter_if.slave   b_if,
    output logic [DATA_W-1:0]    rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Registered state
    state_t            state_q,     state_d;
    req_id_t           sel_q,       sel_d;      // requester owning the current transaction
    req_id_t           last_q,      last_d;     // most recent winner, loses the next tie
    logic              is_read_q,   is_read_d;  // current transaction is a read
    logic              a_gnt_q,     a_gnt_d;
    logic              b_gnt_q,     b_gnt_d;
    logic              a_rvalid_q,  a_rvalid_d;
    logic              b_rvalid_q,  b_rvalid_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    // Winner of arbitration in IDLE (meaningful only when some req is high)
    req_id_t           pick;

    // Next-state, arbitration and registered-output computation
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned; otherwise synthesis would infer a latch.
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        is_read_d   = is_read_q;
        a_gnt_d     = 1'b0;
        b_gnt_d     = 1'b0;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;    // hold last value while the port is idle
        mem_wdata_d = mem_wdata_q;
        pick        = REQ_A;

        unique case (state_q)
            ST_IDLE: begin
                if (a_if.req || b_if.req) begin
                    // A tie goes to whoever did not win last; a lone
                    // requester always wins regardless of history.
                    if (a_if.req && b_if.req) begin
                        pick = (last_q == REQ_B) ? REQ_A : REQ_B;
                    end else begin
                        pick = b_if.req ? REQ_B : REQ_A;
                    end

                    sel_d    = pick;
                    last_d   = pick;
                    mem_en_d = 1'b1;
                    state_d  = ST_ACCESS;

                    if (pick == REQ_B) begin
                        mem_we_d    = b_if.we;
                        mem_addr_d  = b_if.addr;
                        mem_wdata_d = b_if.wdata;
                        is_read_d   = ~b_if.we;
                        b_gnt_d     = 1'b1;
                    end else begin
                        mem_we_d    = a_if.we;
                        mem_addr_d  = a_if.addr;
                        mem_wdata_d = a_if.wdata;
                        is_read_d   = ~a_if.we;
                        a_gnt_d     = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                // RAM port drops back to idle; reads flag the response cycle.
                // Requests are not looked at here even though the winner's
                // req may still be high.
                if (is_read_q) begin
                    a_rvalid_d = (sel_q == REQ_A);
                    b_rvalid_d = (sel_q == REQ_B);
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // mem_rdata is valid this cycle; the rvalid pulse ends here.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= REQ_A;
            last_q      <= REQ_B;        // so that A wins the first tie
            is_read_q   <= 1'b0;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample its
            // pre-edge inputs, so the order of these lines does not matter.
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            is_read_q   <= is_read_d;
            a_gnt_q     <= a_gnt_d;
            b_gnt_q     <= b_gnt_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Output wiring
    assign a_if.gnt    = a_gnt_q;
    assign b_if.gnt    = b_gnt_q;
    assign a_if.rvalid = a_rvalid_q;
    assign b_if.rvalid = b_rvalid_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata       = mem_rdata;
    assign busy        = (state_q != ST_IDLE);

endmodule
